// File: rtl/game_flow_controller.sv
// Billiard game flow controller: stage setup strobe, per-stage countdown, BCD score with
// called-pocket bonus, lives, timed win/lose hold phases and final game-over.
module game_flow_controller #(
  parameter int NUM_BALLS     = 2,
  parameter int NUM_STAGES    = 4,
  parameter int LIVES         = 3,
  parameter int STAGE_SECS    = 60,
  parameter int WIN_SECS      = 2,
  parameter int LOSE_SECS     = 3,
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_BALLS:0]   balls_in_game,
  input  logic [NUM_BALLS:0]   ballhole_collide,
  input  logic [2:0]           curr_Hole_id,
  output logic                 stage_setup,
  output logic                 winPulse,
  output logic                 losePulse,
  output logic                 scoredPulse,
  output logic [2:0]           request_hole,
  output logic [3:0]           scoreL,
  output logic [3:0]           scoreH,
  output logic [3:0]           stage_num,
  output logic [2:0]           lives_left,
  output logic [7:0]           time_left,
  output logic                 game_over,
  output logic                 game_won
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] TICK_MAX = CW'(TICKS_PER_SEC - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_PLAY      = 3'd2,
    S_WIN_HOLD  = 3'd3,
    S_LOSE_HOLD = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   sec_cnt_r;
  logic [3:0]      hold_cnt_r;

  logic            tick_s;
  logic [3:0]      hits_s;
  logic [4:0]      gain_s;
  logic [4:0]      lo_sum_s;
  logic            carry_s;
  logic [3:0]      lo_adj_s;
  logic [4:0]      hi_sum_s;
  logic [3:0]      score_lo_s;
  logic [3:0]      score_hi_s;
  logic            fail_s;
  logic            win_s;

  function automatic logic [3:0] popcnt(input logic [NUM_BALLS-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  function automatic logic [2:0] mod6(input logic [3:0] v);
    logic [3:0] s;
    s = v;
    if (s >= 4'd12) begin
      s = s - 4'd12;
    end else if (s >= 4'd6) begin
      s = s - 4'd6;
    end else begin
      s = v;
    end
    return 3'(s);
  endfunction

  // Scoring arithmetic, fail and win detection for the current cycle
  always_comb begin
    tick_s   = (sec_cnt_r == TICK_MAX);
    hits_s   = popcnt(ballhole_collide[NUM_BALLS:1]);
    gain_s   = {1'b0, hits_s};
    if ((hits_s != 4'd0) && (curr_Hole_id == request_hole)) begin
      gain_s = gain_s + 5'd1;
    end else begin
      gain_s = {1'b0, hits_s};
    end
    lo_sum_s = {1'b0, scoreL} + gain_s;
    carry_s  = (lo_sum_s >= 5'd10);
    if (carry_s) begin
      lo_adj_s = 4'(lo_sum_s - 5'd10);
    end else begin
      lo_adj_s = lo_sum_s[3:0];
    end
    hi_sum_s = {1'b0, scoreH} + {4'b0000, carry_s};
    // A tens digit past 9 means the score went above 99: pin it there
    if (hi_sum_s > 5'd9) begin
      score_hi_s = 4'd9;
      score_lo_s = 4'd9;
    end else begin
      score_hi_s = hi_sum_s[3:0];
      score_lo_s = lo_adj_s;
    end
    fail_s = ballhole_collide[0] || (tick_s && (time_left == 8'd1));
    win_s  = (balls_in_game[NUM_BALLS:1] == {NUM_BALLS{1'b0}}) && balls_in_game[0];
  end

  // Game state machine with registered strobes and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      sec_cnt_r    <= {CW{1'b0}};
      hold_cnt_r   <= 4'd0;
      stage_setup  <= 1'b0;
      winPulse     <= 1'b0;
      losePulse    <= 1'b0;
      scoredPulse  <= 1'b0;
      request_hole <= 3'd0;
      scoreL       <= 4'd0;
      scoreH       <= 4'd0;
      stage_num    <= 4'd0;
      lives_left   <= 3'(LIVES);
      time_left    <= 8'd0;
      game_over    <= 1'b0;
      game_won     <= 1'b0;
    end else begin
      stage_setup <= 1'b0;
      winPulse    <= 1'b0;
      losePulse   <= 1'b0;
      scoredPulse <= 1'b0;
      sec_cnt_r   <= tick_s ? {CW{1'b0}} : sec_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      case (state_r)
        S_IDLE: begin
          if (start) begin
            stage_num   <= 4'd1;
            stage_setup <= 1'b1;
            state_r     <= S_SETUP;
          end
        end
        S_SETUP: begin
          sec_cnt_r    <= {CW{1'b0}};
          time_left    <= 8'(STAGE_SECS);
          request_hole <= mod6(stage_num - 4'd1);
          state_r      <= S_PLAY;
        end
        S_PLAY: begin
          if (hits_s != 4'd0) begin
            scoreL      <= score_lo_s;
            scoreH      <= score_hi_s;
            scoredPulse <= 1'b1;
          end
          if (tick_s && (time_left != 8'd0)) begin
            time_left <= time_left - 8'd1;
          end
          // A lost ball or timeout outranks clearing the table in the same cycle
          if (fail_s) begin
            lives_left <= lives_left - 3'd1;
            losePulse  <= 1'b1;
            sec_cnt_r  <= {CW{1'b0}};
            hold_cnt_r <= 4'd0;
            state_r    <= S_LOSE_HOLD;
          end else if (win_s) begin
            winPulse   <= 1'b1;
            sec_cnt_r  <= {CW{1'b0}};
            hold_cnt_r <= 4'd0;
            state_r    <= S_WIN_HOLD;
          end
        end
        S_WIN_HOLD: begin
          if (tick_s) begin
            if (hold_cnt_r == 4'(WIN_SECS - 1)) begin
              if (stage_num < 4'(NUM_STAGES)) begin
                stage_num   <= stage_num + 4'd1;
                stage_setup <= 1'b1;
                state_r     <= S_SETUP;
              end else begin
                game_over <= 1'b1;
                game_won  <= 1'b1;
                state_r   <= S_DONE;
              end
            end else begin
              hold_cnt_r <= hold_cnt_r + 4'd1;
            end
          end
        end
        S_LOSE_HOLD: begin
          if (tick_s) begin
            if (hold_cnt_r == 4'(LOSE_SECS - 1)) begin
              if (lives_left == 3'd0) begin
                game_over <= 1'b1;
                game_won  <= 1'b0;
                state_r   <= S_DONE;
              end else begin
                stage_setup <= 1'b1;
                state_r     <= S_SETUP;
              end
            end else begin
              hold_cnt_r <= hold_cnt_r + 4'd1;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            scoreL      <= 4'd0;
            scoreH      <= 4'd0;
            lives_left  <= 3'(LIVES);
            game_over   <= 1'b0;
            game_won    <= 1'b0;
            stage_num   <= 4'd1;
            stage_setup <= 1'b1;
            state_r     <= S_SETUP;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller: a per-cycle vector table for the opening
// stage, then hand-written sequences for holds, timeout, game over, saturation and reset.
module tb_game_flow_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] balls_in_game;
  logic [2:0] ballhole_collide;
  logic [2:0] curr_Hole_id;
  logic       stage_setup, winPulse, losePulse, scoredPulse;
  logic [2:0] request_hole;
  logic [3:0] scoreL, scoreH, stage_num;
  logic [2:0] lives_left;
  logic [7:0] time_left;
  logic       game_over, game_won;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  game_flow_controller #(
    .NUM_BALLS(2), .NUM_STAGES(2), .LIVES(2), .STAGE_SECS(5),
    .WIN_SECS(2), .LOSE_SECS(3), .TICKS_PER_SEC(10)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .balls_in_game(balls_in_game), .ballhole_collide(ballhole_collide),
    .curr_Hole_id(curr_Hole_id), .stage_setup(stage_setup),
    .winPulse(winPulse), .losePulse(losePulse), .scoredPulse(scoredPulse),
    .request_hole(request_hole), .scoreL(scoreL), .scoreH(scoreH),
    .stage_num(stage_num), .lives_left(lives_left), .time_left(time_left),
    .game_over(game_over), .game_won(game_won)
  );

  typedef struct {
    logic        rst;
    logic        st;
    logic [2:0]  b;
    logic [2:0]  c;
    logic [2:0]  h;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mkv(input int rst, st, b, c, h, su, sp, wp, lp,
                               input int sh, sl, stg, lv, tl, rh, go, gw);
    vec_t v;
    v.rst = 1'(rst);
    v.st  = 1'(st);
    v.b   = 3'(b);
    v.c   = 3'(c);
    v.h   = 3'(h);
    v.exp = {1'(su), 1'(sp), 1'(wp), 1'(lp), 4'(sh), 4'(sl), 4'(stg),
             3'(lv), 8'(tl), 3'(rh), 1'(go), 1'(gw)};
    return v;
  endfunction

  function automatic logic [31:0] outs();
    return {stage_setup, scoredPulse, winPulse, losePulse, scoreH, scoreL, stage_num,
            lives_left, time_left, request_hole, game_over, game_won};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 stage_setup, 1 losePulse, other game_over; n = limit+1 when the bound expires
  task automatic wait_for(input int sel, input int limit, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < limit) begin
      step();
      n++;
      case (sel)
        0:       hit = stage_setup;
        1:       hit = losePulse;
        default: hit = game_over;
      endcase
    end
    if (!hit) n = limit + 1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; balls_in_game = 3'b111;
    ballhole_collide = 3'b000; curr_Hole_id = 3'd0;

    //            rst st  b      c      h  su sp wp lp sh sl stg lv tl rh go gw
    vecs[0]  = mkv(1, 0, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    vecs[1]  = mkv(0, 1, 3'b111, 3'b010, 0, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
    vecs[2]  = mkv(0, 0, 3'b111, 3'b010, 0, 0, 0, 0, 0, 0, 0, 1, 2, 5, 0, 0, 0);
    vecs[3]  = mkv(0, 0, 3'b111, 3'b010, 0, 0, 1, 0, 0, 0, 2, 1, 2, 5, 0, 0, 0);
    vecs[4]  = mkv(0, 0, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 2, 1, 2, 5, 0, 0, 0);
    vecs[5]  = mkv(0, 0, 3'b111, 3'b110, 4, 0, 1, 0, 0, 0, 4, 1, 2, 5, 0, 0, 0);
    vecs[6]  = mkv(0, 0, 3'b111, 3'b000, 4, 0, 0, 0, 0, 0, 4, 1, 2, 5, 0, 0, 0);
    vecs[7]  = mkv(0, 0, 3'b111, 3'b100, 0, 0, 1, 0, 0, 0, 6, 1, 2, 5, 0, 0, 0);
    vecs[8]  = mkv(0, 0, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 6, 1, 2, 5, 0, 0, 0);
    vecs[9]  = mkv(0, 0, 3'b111, 3'b110, 0, 0, 1, 0, 0, 0, 9, 1, 2, 5, 0, 0, 0);
    vecs[10] = mkv(0, 0, 3'b111, 3'b010, 1, 0, 1, 0, 0, 1, 0, 1, 2, 5, 0, 0, 0);
    vecs[11] = mkv(0, 0, 3'b111, 3'b000, 0, 0, 0, 0, 0, 1, 0, 1, 2, 5, 0, 0, 0);
    vecs[12] = mkv(0, 0, 3'b111, 3'b000, 0, 0, 0, 0, 0, 1, 0, 1, 2, 4, 0, 0, 0);
    vecs[13] = mkv(0, 0, 3'b001, 3'b000, 0, 0, 0, 1, 0, 1, 0, 1, 2, 4, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      reset = vecs[i].rst; start = vecs[i].st; balls_in_game = vecs[i].b;
      ballhole_collide = vecs[i].c; curr_Hole_id = vecs[i].h;
      step();
      chk($sformatf("vec%0d", i), 64'(outs()), 64'(vecs[i].exp));
    end

    // Stage 1 win hold: 20 cycles in total, then re-rack for stage 2
    balls_in_game = 3'b111; ballhole_collide = 3'b000;
    step();
    chk("win_pulse_one_cycle", 64'(winPulse), 64'd0);
    wait_for(0, 100, n);
    chk("win_hold_len", 64'(n), 64'd19);
    chk("stage2_num", 64'(stage_num), 64'd2);
    step();
    chk("stage2_hole", 64'(request_hole), 64'd1);
    chk("stage2_time", 64'(time_left), 64'd5);
    chk("setup_one_cycle", 64'(stage_setup), 64'd0);

    // White ball potted while the table is clear: fail wins over win
    balls_in_game = 3'b001; ballhole_collide = 3'b001;
    step();
    chk("fail_beats_win_lose", 64'(losePulse), 64'd1);
    chk("fail_beats_win_win", 64'(winPulse), 64'd0);
    chk("fail_lives", 64'(lives_left), 64'd1);
    balls_in_game = 3'b111; ballhole_collide = 3'b000;
    step();
    chk("lose_pulse_one_cycle", 64'(losePulse), 64'd0);
    wait_for(0, 100, n);
    chk("lose_hold_len", 64'(n), 64'd29);
    chk("retry_stage", 64'(stage_num), 64'd2);
    chk("retry_score", 64'({scoreH, scoreL}), 64'h10);
    step();

    // Timeout: time_left counts 5..0 over 50 quiet cycles, last tick fails the stage
    for (int k = 1; k <= 50; k++) begin
      step();
      chk($sformatf("countdown_%0d", k), 64'(time_left), 64'(5 - k / 10));
      chk($sformatf("timeout_lose_%0d", k), 64'(losePulse), 64'(k == 50));
    end
    chk("timeout_lives", 64'(lives_left), 64'd0);
    step();
    wait_for(2, 100, n);
    chk("gameover_len", 64'(n), 64'd29);
    chk("gameover_lost", 64'(game_won), 64'd0);

    // Restart from DONE, then drive the score into saturation
    start = 1'b1;
    step();
    chk("restart_outs", 64'(outs()), 64'({1'b1, 3'b000, 8'h00, 4'd1, 3'd2, time_left, request_hole, 2'b00}));
    start = 1'b0;
    step();
    chk("restart_hole", 64'(request_hole), 64'd0);
    ballhole_collide = 3'b110; curr_Hole_id = 3'd0;
    for (int k = 0; k < 32; k++) step();
    chk("score_96", 64'({scoreH, scoreL}), 64'h96);
    curr_Hole_id = 3'd5;
    step();
    chk("score_98", 64'({scoreH, scoreL}), 64'h98);
    curr_Hole_id = 3'd0;
    step();
    chk("score_sat", 64'({scoreH, scoreL}), 64'h99);
    chk("score_sat_pulse", 64'(scoredPulse), 64'd1);
    ballhole_collide = 3'b000;
    step();
    chk("sat_time", 64'(time_left), 64'd2);

    // Clear both stages to reach a won game
    balls_in_game = 3'b001;
    step();
    chk("win2_pulse", 64'(winPulse), 64'd1);
    balls_in_game = 3'b111;
    wait_for(0, 100, n);
    chk("win_hold_len2", 64'(n), 64'd20);
    step();
    balls_in_game = 3'b001;
    step();
    chk("final_win_pulse", 64'(winPulse), 64'd1);
    balls_in_game = 3'b111;
    wait_for(2, 100, n);
    chk("final_hold_len", 64'(n), 64'd20);
    chk("game_won", 64'(game_won), 64'd1);
    chk("final_score", 64'({scoreH, scoreL}), 64'h99);

    // Reset in the middle of a win hold returns straight to IDLE
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    balls_in_game = 3'b001;
    step();
    chk("pre_reset_win", 64'(winPulse), 64'd1);
    balls_in_game = 3'b111;
    step(); step(); step();
    reset = 1'b1;
    step();
    chk("reset_in_hold", 64'(outs()), 64'({4'b0000, 8'h00, 4'd0, 3'd2, 8'd0, 3'd0, 2'b00}));
    reset = 1'b0; ballhole_collide = 3'b010;
    step();
    ballhole_collide = 3'b000;
    step(); step();
    chk("idle_after_reset", 64'(outs()), 64'({4'b0000, 8'h00, 4'd0, 3'd2, 8'd0, 3'd0, 2'b00}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
